branch_target_buffer: RTL

- Fetch-side predictor that feeds the program counter its `take_branch` / `branch_predict` pair.
- Direct-mapped BTB, one 2-bit saturating direction counter per entry, indexed by the fetch PC.
- Trained by branch resolution from execute: the same event that drives the PC flush / `branch_address` path.
- Also keeps a saturating mispredict counter for performance debug.

---
 rtl/branch_target_buffer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/branch_target_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : branch_target_buffer
//  Description : Direct-mapped branch target buffer with a 2-bit saturating
//                direction counter per entry. Combinational lookup on the
//                fetch PC, registered training from branch resolution, and a
//                saturating mispredict counter for performance debug.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_target_buffer #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INDEX_BITS  = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [ADDR_WIDTH-1:0]  pc,
  output logic                   take_branch,
  output logic [ADDR_WIDTH-1:0]  branch_predict,
  input  logic                   update_valid,
  input  logic [ADDR_WIDTH-1:0]  update_pc,
  input  logic                   update_taken,
  input  logic [ADDR_WIDTH-1:0]  update_target,
  input  logic                   update_mispredict,
  output logic [COUNT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  // Bit 0 of an address is always zero for 2-byte aligned code, so the
  // index starts at bit 1 and the tag takes everything above the index.
  localparam int TAG_W   = ADDR_WIDTH - INDEX_BITS - 1;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // Table state
  logic                  valid_q  [ENTRIES];
  logic                  valid_d  [ENTRIES];
  logic [TAG_W-1:0]      tag_q    [ENTRIES];
  logic [TAG_W-1:0]      tag_d    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [1:0]            ctr_d    [ENTRIES];

  logic [COUNT_WIDTH-1:0] mispredict_count_q;
  logic [COUNT_WIDTH-1:0] mispredict_count_d;

  // Address decode for both ports
  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [TAG_W-1:0]      w_lk_tag;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic [TAG_W-1:0]      w_up_tag;
  logic                  w_lk_hit;
  logic                  w_up_hit;

  assign w_lk_idx = pc[INDEX_BITS:1];
  assign w_lk_tag = pc[ADDR_WIDTH-1:INDEX_BITS+1];
  assign w_up_idx = update_pc[INDEX_BITS:1];
  assign w_up_tag = update_pc[ADDR_WIDTH-1:INDEX_BITS+1];

  // Zero-latency lookup; reads the registered state, so a same-cycle update
  // to this entry only becomes visible on the following cycle.
  always_comb begin
    w_lk_hit       = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
    take_branch    = w_lk_hit && ctr_q[w_lk_idx][1];
    branch_predict = take_branch ? target_q[w_lk_idx]
                                 : pc + ADDR_WIDTH'(2);
  end

  // Training: counter step on a hit, allocate on a taken miss, ignore a
  // not-taken miss so an unrelated live entry is not evicted.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);
    if (update_valid) begin
      if (w_up_hit) begin
        if (update_taken) begin
          target_d[w_up_idx] = update_target;
          if (ctr_q[w_up_idx] != CTR_ST) begin
            ctr_d[w_up_idx] = ctr_q[w_up_idx] + 2'd1;
          end
        end else if (ctr_q[w_up_idx] != CTR_SNT) begin
          ctr_d[w_up_idx] = ctr_q[w_up_idx] - 2'd1;
        end
      end else if (update_taken) begin
        valid_d[w_up_idx]  = 1'b1;
        tag_d[w_up_idx]    = w_up_tag;
        target_d[w_up_idx] = update_target;
        ctr_d[w_up_idx]    = CTR_WT;
      end
    end
  end

  // Mispredict counter saturates at all-ones instead of wrapping.
  always_comb begin
    mispredict_count_d = mispredict_count_q;
    if (update_valid && update_mispredict && (mispredict_count_q != '1)) begin
      mispredict_count_d = mispredict_count_q + COUNT_WIDTH'(1);
    end
  end

  assign mispredict_count = mispredict_count_q;

  // State registers; the whole flop array clears asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

endmodule
`default_nettype wire
